mem_bus_arbiter: RTL and testbench

//  Shares the single data-memory/peripheral Bus between two requesters:
//  - the CPU MEM stage;
//  - a DMA/peripheral master.

---
 rtl/mem_bus_arbiter_pkg.sv | 24 ++
 rtl/mem_bus_arbiter_rr_arb2.sv | 22 ++
 rtl/mem_bus_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the CPU/DMA memory bus arbiter: FSM states, owner ids and
// the WAIT down-counter sizing.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } owner_e;

  // Wide enough for MEM_LAT-1 with MEM_LAT up to 15.
  localparam int unsigned LAT_CNT_W = 4;

  function automatic logic [LAT_CNT_W-1:0] wait_load(input int unsigned mem_lat);
    return LAT_CNT_W'(mem_lat - 1);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin picker: index 0 is the CPU, index 1 the DMA master.
// On a tie the requester that was not served last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);
  import mem_bus_arbiter_pkg::*;

  always_comb begin
    gnt_valid = |req;
    gnt_id    = OWNER_CPU;
    case (req)
      2'b01:   gnt_id = OWNER_CPU;
      2'b10:   gnt_id = OWNER_DMA;
      2'b11:   gnt_id = ~last;
      default: gnt_id = OWNER_CPU;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises CPU MEM-stage and DMA accesses onto one memory/peripheral bus,
// one transaction at a time, and stalls the CPU until its own access completes.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_wr,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_rd,
  output logic              bus_wr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata
);
  import mem_bus_arbiter_pkg::*;

  state_e               state_q;
  owner_e               owner_q;
  owner_e               last_q;
  logic                 wr_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [DATA_W-1:0]    cpu_rdata_q;
  logic [DATA_W-1:0]    dma_rdata_q;
  logic [LAT_CNT_W-1:0] cnt_q;
  logic                 bus_rd_q;
  logic                 bus_wr_q;

  logic                 gnt_valid;
  logic                 gnt_id;

  rr_arb2 u_rr_arb2 (
    .req       ({dma_req, cpu_req}),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWNER_CPU;
      last_q      <= OWNER_DMA;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cnt_q       <= '0;
      bus_rd_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
    end else begin
      // Strobes are raised on entry to ACCESS so they are high for that cycle only.
      bus_rd_q <= 1'b0;
      bus_wr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            owner_q <= owner_e'(gnt_id);
            last_q  <= owner_e'(gnt_id);
            if (gnt_id == OWNER_DMA) begin
              wr_q     <= dma_wr;
              addr_q   <= dma_addr;
              wdata_q  <= dma_wdata;
              bus_rd_q <= ~dma_wr;
              bus_wr_q <= dma_wr;
            end else begin
              wr_q     <= cpu_wr;
              addr_q   <= cpu_addr;
              wdata_q  <= cpu_wdata;
              bus_rd_q <= ~cpu_wr;
              bus_wr_q <= cpu_wr;
            end
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (wr_q) begin
            state_q <= ST_DONE;
          end else begin
            cnt_q   <= wait_load(MEM_LAT);
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            if (owner_q == OWNER_DMA) begin
              dma_rdata_q <= bus_rdata;
            end else begin
              cpu_rdata_q <= bus_rdata;
            end
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - LAT_CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Reset is folded in so the stall simply tracks cpu_req while reset is held.
  always_comb begin
    cpu_stall = cpu_req & ~(~reset & (state_q == ST_DONE) & (owner_q == OWNER_CPU));
  end

  assign dma_ack   = (state_q == ST_DONE) & (owner_q == OWNER_DMA);
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_rd    = bus_rd_q;
  assign bus_wr    = bus_wr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter with MEM_LAT = 2, 1 and 15.
module tb_mem_bus_arbiter;

  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // MEM_LAT = 2 instance
  logic        cpu_req, cpu_wr, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_wr, dma_ack;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        bus_rd, bus_wr;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [31:0] mem_val;

  // MEM_LAT = 1 instance
  logic        a_cpu_req, a_cpu_wr, a_cpu_stall;
  logic [31:0] a_cpu_addr, a_cpu_wdata, a_cpu_rdata;
  logic        a_dma_req, a_dma_wr, a_dma_ack;
  logic [31:0] a_dma_addr, a_dma_wdata, a_dma_rdata;
  logic        a_bus_rd, a_bus_wr;
  logic [31:0] a_bus_addr, a_bus_wdata, a_bus_rdata;
  logic [31:0] a_val;

  // MEM_LAT = 15 instance
  logic        b_cpu_req, b_cpu_wr, b_cpu_stall;
  logic [31:0] b_cpu_addr, b_cpu_wdata, b_cpu_rdata;
  logic        b_dma_req, b_dma_wr, b_dma_ack;
  logic [31:0] b_dma_addr, b_dma_wdata, b_dma_rdata;
  logic        b_bus_rd, b_bus_wr;
  logic [31:0] b_bus_addr, b_bus_wdata, b_bus_rdata;
  logic [31:0] b_val;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata)
  );

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_lat1 (
    .clk(clk), .reset(reset),
    .cpu_req(a_cpu_req), .cpu_wr(a_cpu_wr), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_rdata(a_cpu_rdata), .cpu_stall(a_cpu_stall),
    .dma_req(a_dma_req), .dma_wr(a_dma_wr), .dma_addr(a_dma_addr), .dma_wdata(a_dma_wdata),
    .dma_rdata(a_dma_rdata), .dma_ack(a_dma_ack),
    .bus_addr(a_bus_addr), .bus_rd(a_bus_rd), .bus_wr(a_bus_wr), .bus_wdata(a_bus_wdata),
    .bus_rdata(a_bus_rdata)
  );

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(15)) dut_lat15 (
    .clk(clk), .reset(reset),
    .cpu_req(b_cpu_req), .cpu_wr(b_cpu_wr), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
    .dma_req(b_dma_req), .dma_wr(b_dma_wr), .dma_addr(b_dma_addr), .dma_wdata(b_dma_wdata),
    .dma_rdata(b_dma_rdata), .dma_ack(b_dma_ack),
    .bus_addr(b_bus_addr), .bus_rd(b_bus_rd), .bus_wr(b_bus_wr), .bus_wdata(b_bus_wdata),
    .bus_rdata(b_bus_rdata)
  );

  // Memory models: read data is valid only during the cycle MEM_LAT after the strobe.
  task automatic serve_main(input logic [31:0] v);
    repeat (2) @(posedge clk);
    #1 bus_rdata = v;
    @(posedge clk);
    #1 bus_rdata = JUNK;
  endtask

  always @(negedge clk) if (bus_rd === 1'b1) fork serve_main(mem_val); join_none

  always @(negedge clk) if (a_bus_rd === 1'b1) fork
    begin
      @(posedge clk);
      #1 a_bus_rdata = a_val;
      @(posedge clk);
      #1 a_bus_rdata = JUNK;
    end
  join_none

  always @(negedge clk) if (b_bus_rd === 1'b1) fork
    begin
      repeat (15) @(posedge clk);
      #1 b_bus_rdata = b_val;
      @(posedge clk);
      #1 b_bus_rdata = JUNK;
    end
  join_none

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (3) cyc;
    @(negedge clk);
    checks++; if (bus_rd !== 1'b0) begin failures++; $display("FAIL reset_bus_rd: got %b expected 0", bus_rd); end
    checks++; if (bus_wr !== 1'b0) begin failures++; $display("FAIL reset_bus_wr: got %b expected 0", bus_wr); end
    checks++; if (bus_addr !== 32'h0) begin failures++; $display("FAIL reset_bus_addr: got %h expected 0", bus_addr); end
    checks++; if (bus_wdata !== 32'h0) begin failures++; $display("FAIL reset_bus_wdata: got %h expected 0", bus_wdata); end
    checks++; if (cpu_rdata !== 32'h0) begin failures++; $display("FAIL reset_cpu_rdata: got %h expected 0", cpu_rdata); end
    checks++; if (dma_rdata !== 32'h0) begin failures++; $display("FAIL reset_dma_rdata: got %h expected 0", dma_rdata); end
    checks++; if (dma_ack !== 1'b0) begin failures++; $display("FAIL reset_dma_ack: got %b expected 0", dma_ack); end
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL reset_stall_idle: got %b expected 0", cpu_stall); end
    cpu_req = 1'b1;
    #1;
    checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL reset_stall_follows_req: got %b expected 1", cpu_stall); end
    cyc;
    reset   = 1'b0;
    cpu_req = 1'b0;
  endtask

  task automatic test_cpu_write;
    int unsigned n_stall = 0;
    int unsigned n_wr = 0;
    int unsigned n_rd = 0;
    logic [31:0] wa = '0;
    logic [31:0] wd = '0;
    cyc;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h4000_0010; cpu_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus_wr === 1'b1) begin n_wr++; wa = bus_addr; wd = bus_wdata; end
      if (bus_rd === 1'b1) n_rd++;
      if (cpu_stall !== 1'b1) break;
      n_stall++;
      cyc;
    end
    checks++; if (n_stall != 2) begin failures++; $display("FAIL wr_stall_cycles: got %0d expected 2", n_stall); end
    checks++; if (n_wr != 1) begin failures++; $display("FAIL wr_strobe_count: got %0d expected 1", n_wr); end
    checks++; if (n_rd != 0) begin failures++; $display("FAIL wr_no_rd_strobe: got %0d expected 0", n_rd); end
    checks++; if (wa !== 32'h4000_0010) begin failures++; $display("FAIL wr_addr: got %h expected 40000010", wa); end
    checks++; if (wd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_data: got %h expected deadbeef", wd); end
    cyc;
    cpu_req = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic test_cpu_read;
    int unsigned n_stall = 0;
    int unsigned n_rd = 0;
    cyc;
    mem_val = 32'h1234_5678;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h4000_0020;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus_rd === 1'b1) n_rd++;
      if (cpu_stall !== 1'b1) break;
      n_stall++;
      cyc;
    end
    checks++; if (n_stall != 4) begin failures++; $display("FAIL rd_stall_cycles: got %0d expected 4", n_stall); end
    checks++; if (n_rd != 1) begin failures++; $display("FAIL rd_strobe_count: got %0d expected 1", n_rd); end
    checks++; if (cpu_rdata !== 32'h1234_5678) begin failures++; $display("FAIL rd_data: got %h expected 12345678", cpu_rdata); end
    cyc;
    cpu_req = 1'b0;
  endtask

  task automatic test_tie_alternate;
    logic [31:0] order [4];
    int          at    [4];
    int          n     = 0;
    int          acks  = 0;
    int          lows  = 0;
    logic [31:0] exp_addr [4];
    int          exp_at   [4];
    exp_addr[0] = 32'h100; exp_addr[1] = 32'h200; exp_addr[2] = 32'h100; exp_addr[3] = 32'h200;
    exp_at[0] = 1; exp_at[1] = 4; exp_at[2] = 7; exp_at[3] = 10;
    for (int k = 0; k < 4; k++) begin order[k] = '0; at[k] = -1; end
    reset = 1'b1;
    cyc; cyc;
    reset = 1'b0;
    cyc;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'h1;
    dma_req = 1'b1; dma_wr = 1'b1; dma_addr = 32'h200; dma_wdata = 32'h2;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) cyc;
      @(negedge clk);
      if (bus_wr === 1'b1 && n < 4) begin order[n] = bus_addr; at[n] = i; n++; end
      if (dma_ack === 1'b1) acks++;
      if (cpu_stall !== 1'b1) lows++;
    end
    for (int k = 0; k < 4; k++) begin
      checks++; if (order[k] !== exp_addr[k]) begin failures++; $display("FAIL tie_grant_order[%0d]: got addr %h expected %h", k, order[k], exp_addr[k]); end
      checks++; if (at[k] != exp_at[k]) begin failures++; $display("FAIL tie_grant_cycle[%0d]: got %0d expected %0d", k, at[k], exp_at[k]); end
    end
    checks++; if (acks != 2) begin failures++; $display("FAIL tie_dma_acks: got %0d expected 2", acks); end
    checks++; if (lows != 2) begin failures++; $display("FAIL tie_stall_low_cycles: got %0d expected 2", lows); end
    cyc;
    cpu_req = 1'b0; dma_req = 1'b0; cpu_wr = 1'b0; dma_wr = 1'b0;
  endtask

  task automatic test_dma_wait_cpu;
    int          n_ack = 0;
    int          ack_cyc = -1;
    logic [31:0] ack_data = '0;
    int          cpu_acc = -1;
    int          n_stall = 0;
    int          low_cyc = -1;
    logic [31:0] rd_at_low = '0;
    cyc;
    mem_val = 32'hCAFE_F00D;
    dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 32'h300;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cyc;
      if (i == 2) begin cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h400; end
      if (i == 5) begin dma_req = 1'b0; mem_val = 32'h7E57_0004; end
      @(negedge clk);
      if (dma_ack === 1'b1) begin n_ack++; ack_cyc = i; ack_data = dma_rdata; end
      if (bus_rd === 1'b1 && bus_addr === 32'h400) cpu_acc = i;
      if (i >= 2 && cpu_stall === 1'b1) n_stall++;
      if (i >= 2 && cpu_stall !== 1'b1 && low_cyc < 0) begin low_cyc = i; rd_at_low = cpu_rdata; end
    end
    checks++; if (n_ack != 1) begin failures++; $display("FAIL dw_ack_count: got %0d expected 1", n_ack); end
    checks++; if (ack_cyc != 4) begin failures++; $display("FAIL dw_ack_cycle: got %0d expected 4", ack_cyc); end
    checks++; if (ack_data !== 32'hCAFE_F00D) begin failures++; $display("FAIL dw_dma_rdata: got %h expected cafef00d", ack_data); end
    // One IDLE cycle separates the DMA DONE from the CPU ACCESS.
    checks++; if (cpu_acc != 6) begin failures++; $display("FAIL dw_cpu_access_cycle: got %0d expected 6", cpu_acc); end
    checks++; if (n_stall != 7) begin failures++; $display("FAIL dw_cpu_stall_cycles: got %0d expected 7", n_stall); end
    checks++; if (low_cyc != 9) begin failures++; $display("FAIL dw_cpu_done_cycle: got %0d expected 9", low_cyc); end
    checks++; if (rd_at_low !== 32'h7E57_0004) begin failures++; $display("FAIL dw_cpu_rdata: got %h expected 7e570004", rd_at_low); end
    cyc;
    cpu_req = 1'b0;
  endtask

  task automatic test_reset_in_wait;
    int n_ack = 0;
    int rd_at1 = 0;
    int wr_at4 = 0;
    logic [31:0] wa = '0;
    int low5 = 0;
    cyc;
    mem_val = 32'h5555_AAAA;
    dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 32'h500;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cyc;
      if (i == 2) begin reset = 1'b1; dma_req = 1'b0; end
      if (i == 3) begin reset = 1'b0; cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h600; cpu_wdata = 32'h66; end
      @(negedge clk);
      if (dma_ack === 1'b1) n_ack++;
      if (i == 1 && bus_rd === 1'b1) rd_at1 = 1;
      if (i == 3) begin
        checks++; if (bus_rd !== 1'b0 || bus_wr !== 1'b0) begin failures++; $display("FAIL rw_strobes: got rd=%b wr=%b expected 0 0", bus_rd, bus_wr); end
        checks++; if (dma_rdata !== 32'h0) begin failures++; $display("FAIL rw_dma_rdata: got %h expected 0", dma_rdata); end
        checks++; if (cpu_rdata !== 32'h0) begin failures++; $display("FAIL rw_cpu_rdata: got %h expected 0", cpu_rdata); end
        checks++; if (bus_addr !== 32'h0) begin failures++; $display("FAIL rw_bus_addr: got %h expected 0", bus_addr); end
      end
      if (i == 4 && bus_wr === 1'b1) begin wr_at4 = 1; wa = bus_addr; end
      if (i == 5 && cpu_stall === 1'b0) low5 = 1;
    end
    checks++; if (rd_at1 != 1) begin failures++; $display("FAIL rw_dma_started: got %0d expected 1", rd_at1); end
    checks++; if (n_ack != 0) begin failures++; $display("FAIL rw_no_ack: got %0d expected 0", n_ack); end
    checks++; if (wr_at4 != 1 || wa !== 32'h600) begin failures++; $display("FAIL rw_idle_after_reset: got strobe=%0d addr=%h expected 1 600", wr_at4, wa); end
    checks++; if (low5 != 1) begin failures++; $display("FAIL rw_cpu_done: got %0d expected 1", low5); end
    cyc;
    cpu_req = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic test_mem_lat_edges;
    int unsigned n_stall;
    cyc;
    a_val = 32'h0000_0111;
    a_cpu_req = 1'b1; a_cpu_wr = 1'b0; a_cpu_addr = 32'h700;
    n_stall = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (a_cpu_stall !== 1'b1) break;
      n_stall++;
      cyc;
    end
    checks++; if (n_stall != 3) begin failures++; $display("FAIL lat1_done_cycle: got %0d expected 3", n_stall); end
    checks++; if (a_cpu_rdata !== 32'h0000_0111) begin failures++; $display("FAIL lat1_rdata: got %h expected 00000111", a_cpu_rdata); end
    cyc;
    a_cpu_req = 1'b0;
    cyc;
    b_val = 32'h1515_1515;
    b_cpu_req = 1'b1; b_cpu_wr = 1'b0; b_cpu_addr = 32'h800;
    n_stall = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (b_cpu_stall !== 1'b1) break;
      n_stall++;
      cyc;
    end
    checks++; if (n_stall != 17) begin failures++; $display("FAIL lat15_done_cycle: got %0d expected 17", n_stall); end
    checks++; if (b_cpu_rdata !== 32'h1515_1515) begin failures++; $display("FAIL lat15_rdata: got %h expected 15151515", b_cpu_rdata); end
    cyc;
    b_cpu_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_wr = 1'b0; dma_addr = '0; dma_wdata = '0;
    bus_rdata = JUNK; mem_val = '0;
    a_cpu_req = 1'b0; a_cpu_wr = 1'b0; a_cpu_addr = '0; a_cpu_wdata = '0;
    a_dma_req = 1'b0; a_dma_wr = 1'b0; a_dma_addr = '0; a_dma_wdata = '0;
    a_bus_rdata = JUNK; a_val = '0;
    b_cpu_req = 1'b0; b_cpu_wr = 1'b0; b_cpu_addr = '0; b_cpu_wdata = '0;
    b_dma_req = 1'b0; b_dma_wr = 1'b0; b_dma_addr = '0; b_dma_wdata = '0;
    b_bus_rdata = JUNK; b_val = '0;

    test_reset;
    test_cpu_write;
    test_cpu_read;
    test_tie_alternate;
    test_dma_wait_cpu;
    test_reset_in_wait;
    test_mem_lat_edges;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
